// File: rtl/seq_mult_32x32.sv
// rtl/seq_mult_32x32.sv - sequential shift-and-add 32x32->64 multiplier; optional macro SEQ_MULT_EARLY_TERM_EN

// Carry-lookahead adder: 4-bit lookahead groups chained group to group.
module cla_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] cy;
    logic       cin_grp;

    if (gi == 0) begin : g_first
      assign cin_grp = cin;
    end else begin : g_next
      assign cin_grp = g_grp[gi-1].cy[3];
    end

    assign gg = a[4*gi +: 4] & b[4*gi +: 4];
    assign pp = a[4*gi +: 4] ^ b[4*gi +: 4];

    // every carry in the group is expanded directly from the group carry-in
    assign cy[0] = gg[0] | (pp[0] & cin_grp);
    assign cy[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin_grp);
    assign cy[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cin_grp);
    assign cy[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0])
                 | (pp[3] & pp[2] & pp[1] & pp[0] & cin_grp);

    assign sum[4*gi +: 4] = pp ^ {cy[2:0], cin_grp};
  end

  assign cout = g_grp[15].cy[3];
endmodule

module seq_mult_32x32 #(
  parameter int OP_W  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] product
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2*OP_W-1:0]   acc_q, acc_d;
  logic [2*OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*OP_W-1:0]   product_q, product_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*OP_W-1:0]   add_sum;
  logic                cout_unused;
  logic                last_iter;

  cla_64bit u_cla (
    .a    (acc_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (cout_unused)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  // stop once no set multiplier bits remain above the one being consumed
  assign last_iter = (mplier_q[OP_W-1:1] == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(OP_W - 1));
`endif

  // next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{OP_W{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = ST_RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (b == '0) begin
            state_d   = ST_DONE;
            product_d = '0;
          end
`endif
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) acc_d = add_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d   = ST_DONE;
          product_d = acc_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // all state and outputs registered; asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_seq_mult_32x32.sv
// tb/tb_seq_mult_32x32.sv - self-checking bench for seq_mult_32x32
module tb_seq_mult_32x32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam int IGN_DLY = 3;
`else
  localparam int IGN_DLY = 10;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  seq_mult_32x32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
    for (int i = 31; i >= 0; i--) if (bv[i]) return i + 2;
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int first, output int edges);
    edges = first;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_result(input string name);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({name, "_product"}, product, exp);
    end
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] pv);
    int e;
    logic [63:0] held;
    start = 1'b1; a = av; b = bv;
    sb_q.push_back(pv);
    tick();
    start = 1'b0;
    if (exp_lat(bv) > 1) chk({name, "_busy_run"}, 64'(busy), 64'd1);
    wait_done(1, e);
    check_result(name);
    chk({name, "_latency"}, 64'(e), 64'(exp_lat(bv)));
    held = pv;
    tick();
    chk({name, "_done_width"}, 64'(done), 64'd0);
    chk({name, "_product_held"}, product, held);
  endtask

  initial begin
    int e;
    int saw_done;

    vecs[0] = '{32'd3, 32'd5, 64'h0F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'h1234, 32'd0, 64'd0};
    vecs[3] = '{32'd0, 32'hFFFFFFFF, 64'd0};
    vecs[4] = '{32'd1, 32'h80000000, 64'h80000000};
    vecs[5] = '{32'hFFFFFFFF, 32'd1, 64'hFFFFFFFF};
    for (int i = 6; i < 10; i++) begin
      vecs[i].a = $urandom;
      vecs[i].b = $urandom;
      vecs[i].p = {32'b0, vecs[i].a} * {32'b0, vecs[i].b};
    end

    // reset held: start toggling must not disturb outputs
    tick(); tick();
    start = 1'b1; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_product", product, 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // start while busy is ignored, then back-to-back start in DONE cycle
    start = 1'b1; a = 32'd2; b = 32'd9;
    sb_q.push_back(64'd18);
    tick();
    start = 1'b0;
    for (int i = 1; i < IGN_DLY; i++) tick();
    chk("ign_busy_before", 64'(busy), 64'd1);
    start = 1'b1; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0;
    wait_done(IGN_DLY + 1, e);
    check_result("ign");
    chk("ign_latency", 64'(e), 64'(exp_lat(32'd9)));
    start = 1'b1; a = 32'd7; b = 32'd7;
    sb_q.push_back(64'd49);
    tick();
    start = 1'b0;
    chk("b2b_done_width", 64'(done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_product_stable", product, 64'd18);
    wait_done(1, e);
    check_result("b2b");
    chk("b2b_latency", 64'(e), 64'(exp_lat(32'd7)));
    tick();

    // reset in the middle of an operation
    start = 1'b1; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done++;
    end
    chk("midrst_no_activity", 64'(saw_done), 64'd0);
    run_vec("after_rst", 32'd6, 32'd7, 64'd42);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
